// File: rtl/opb_sw_reg_pkg.sv
// rtl/opb_sw_reg_pkg.sv - shared types and constants for the OPB software registers
//
// Contents:
//   slave_state_e : IDLE / ACK / GAP states of the OPB slave attach
//   reg_sel_e     : decoded register word of a transfer
//   DATA_OFS, STATUS_OFS : byte offsets of the two register words
//   STATUS_NEW, STATUS_OVR, STATUS_CNT_LSB : STATUS bit positions
//   pack_status() : builds the STATUS word from its fields
package opb_sw_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } slave_state_e;

  // SEL_NONE is encoded as 0 so a reset attach carries no stale decode.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_DATA   = 2'd1,
    SEL_STATUS = 2'd2
  } reg_sel_e;

  localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STATUS_NEW     = 0;
  localparam int STATUS_OVR     = 1;
  localparam int STATUS_CNT_LSB = 16;

  function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                              input logic        ovr,
                                              input logic        nw);
    logic [31:0] w;
    w = '0;
    w[STATUS_CNT_LSB +: 16] = cnt;
    w[STATUS_OVR]           = ovr;
    w[STATUS_NEW]           = nw;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_attach.sv
// rtl/opb_slave_attach.sv - OPB single-beat slave: address decode, IDLE/ACK/GAP FSM, bus-bit reversal
//
// Ports:
//   clk, rst_n    : bus clock, asynchronous active-low reset
//   opb_abus      : OPB address, bit 0 = MSB
//   opb_be        : OPB byte enables, opb_be[last] covers the least significant byte
//   opb_dbus      : OPB write data, bit 0 = MSB
//   opb_rnw       : 1 = read, 0 = write
//   opb_select    : transfer request
//   rd_word       : read word for the live decode (req_sel), supplied by the register file
//   sl_dbus       : read data towards the bus, zero outside the ack cycle of a read
//   sl_xferack    : one-cycle transfer acknowledge
//   req_start     : the FSM is accepting a transfer at the coming edge
//   req_sel       : live decode of opb_abus, valid with req_start
//   ack_sel       : decode latched for the transfer being acked
//   ack_rnw       : direction latched for the transfer being acked
//   ack_wdata     : write data latched for the transfer, bit 0 = LSB
//   ack_be        : byte enables latched for the transfer, ack_be[0] covers wdata[7:0]
module opb_slave_attach
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     opb_abus,
  input  logic [0:C_OPB_DWIDTH/8-1]   opb_be,
  input  logic [0:C_OPB_DWIDTH-1]     opb_dbus,
  input  logic                        opb_rnw,
  input  logic                        opb_select,
  input  logic [C_OPB_DWIDTH-1:0]     rd_word,
  output logic [0:C_OPB_DWIDTH-1]     sl_dbus,
  output logic                        sl_xferack,
  output logic                        req_start,
  output reg_sel_e                    req_sel,
  output reg_sel_e                    ack_sel,
  output logic                        ack_rnw,
  output logic [C_OPB_DWIDTH-1:0]     ack_wdata,
  output logic [C_OPB_DWIDTH/8-1:0]   ack_be
);

  localparam int AW = C_OPB_AWIDTH;
  localparam int DW = C_OPB_DWIDTH;

  slave_state_e  state_q, state_d;
  logic [AW-1:0] addr;
  logic [AW-1:0] ofs;
  logic [AW-1:0] word_ofs;
  logic          hit;
  logic [DW-1:0] rd_q;
  logic          unused_ofs;

  // A vector copy renumbers the big-endian bus into a plain [msb:0] value.
  assign addr = opb_abus;
  assign ofs  = addr - C_BASEADDR[AW-1:0];
  assign hit  = opb_select
             && (addr >= C_BASEADDR[AW-1:0])
             && (addr <= C_HIGHADDR[AW-1:0]);

  // The word within the first 8 bytes is picked by ABus[29] alone, so byte
  // addresses inside a word reach that word; beyond 8 bytes nothing decodes.
  assign word_ofs   = {ofs[AW-1:3], opb_abus[AW-3], 2'b00};
  assign unused_ofs = &{1'b0, ofs[2:0]};

  always_comb begin
    req_sel = SEL_NONE;
    if (word_ofs == DATA_OFS[AW-1:0]) begin
      req_sel = SEL_DATA;
    end else if (word_ofs == STATUS_OFS[AW-1:0]) begin
      req_sel = SEL_STATUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // GAP ignores select: the master still drives select during the cycle after
  // the ack, and re-accepting it there would ack one transfer twice.
  always_comb begin
    state_d    = state_q;
    req_start  = 1'b0;
    sl_xferack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d   = ST_ACK;
          req_start = 1'b1;
        end
      end
      ST_ACK: begin
        sl_xferack = 1'b1;
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Everything the ack cycle needs is frozen when the transfer is accepted, so
  // a capture landing on that edge cannot change what the master reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sel   <= SEL_NONE;
      ack_rnw   <= 1'b0;
      ack_wdata <= '0;
      ack_be    <= '0;
      rd_q      <= '0;
    end else if (req_start) begin
      ack_sel   <= req_sel;
      ack_rnw   <= opb_rnw;
      ack_wdata <= opb_dbus;
      ack_be    <= opb_be;
      rd_q      <= opb_rnw ? rd_word : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < DW; i++) begin
      sl_dbus[i] = sl_xferack ? rd_q[DW-1-i] : 1'b0;
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// rtl/opb_register_simulink2ppc.sv - OPB read register carrying one word from user fabric to the PPC
//
// Ports:
//   OPB_Clk, OPB_Rst_n          : shared clock, asynchronous active-low reset
//   OPB_ABus, OPB_BE, OPB_DBus  : OPB address, byte enables, write data (bit 0 = MSB)
//   OPB_RNW, OPB_select         : direction and transfer request
//   OPB_seqAddr                 : ignored, every transfer is a single beat
//   Sl_DBus, Sl_xferAck         : read data and one-cycle acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup : tied low
//   user_data_in, user_data_valid   : fabric word and its capture strobe
//   user_read_ack               : one-cycle pulse in the ack cycle of a DATA read
//
// Registers: 0x0 DATA (read only), 0x4 STATUS {CNT[31:16], OVR[1], NEW[0]}.
module opb_register_simulink2ppc
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid,
  output logic                      user_read_ack
);

  localparam int unused_family_bits = $bits(C_FAMILY);

  logic [31:0] data_q;
  logic        new_q;
  logic        ovr_q;
  logic [15:0] cnt_q;
  logic        cap_on_latch_q;

  reg_sel_e    req_sel;
  reg_sel_e    ack_sel;
  logic        req_start;
  logic        ack_rnw;
  logic [31:0] ack_wdata;
  logic [3:0]  ack_be;
  logic [31:0] rd_word;

  logic        capture;
  logic        data_rd_start;
  logic        data_rd_end;
  logic        status_wr;
  logic        ovr_clr;
  logic        ovr_set;
  logic        unused_ok;

  always_comb begin
    rd_word = '0;
    unique case (req_sel)
      SEL_DATA:   rd_word = data_q;
      SEL_STATUS: rd_word = pack_status(cnt_q, ovr_q, new_q);
      default:    rd_word = '0;
    endcase
  end

  opb_slave_attach #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH)
  ) u_attach (
    .clk        (OPB_Clk),
    .rst_n      (OPB_Rst_n),
    .opb_abus   (OPB_ABus),
    .opb_be     (OPB_BE),
    .opb_dbus   (OPB_DBus),
    .opb_rnw    (OPB_RNW),
    .opb_select (OPB_select),
    .rd_word    (rd_word),
    .sl_dbus    (Sl_DBus),
    .sl_xferack (Sl_xferAck),
    .req_start  (req_start),
    .req_sel    (req_sel),
    .ack_sel    (ack_sel),
    .ack_rnw    (ack_rnw),
    .ack_wdata  (ack_wdata),
    .ack_be     (ack_be)
  );

  assign capture       = user_data_valid;
  assign data_rd_start = req_start && OPB_RNW && (req_sel == SEL_DATA);
  assign data_rd_end   = Sl_xferAck && ack_rnw && (ack_sel == SEL_DATA);
  assign status_wr     = Sl_xferAck && !ack_rnw && (ack_sel == SEL_STATUS);
  assign ovr_clr       = status_wr && ack_be[0] && ack_wdata[STATUS_OVR];

  // A capture on the accept edge or in the ack cycle of a DATA read loses
  // nothing: the word in flight to the PPC is the one being replaced.
  assign ovr_set = capture && new_q && !data_rd_start && !data_rd_end;

  assign user_read_ack = data_rd_end;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q         <= '0;
      new_q          <= 1'b0;
      ovr_q          <= 1'b0;
      cnt_q          <= '0;
      cap_on_latch_q <= 1'b0;
    end else begin
      // Remembers that DATA changed after the read latched it, so the read
      // must not mark the newer, unseen word as consumed.
      cap_on_latch_q <= data_rd_start && capture;

      if (capture) begin
        data_q <= user_data_in;
        cnt_q  <= cnt_q + 16'd1;
      end

      if (capture) begin
        new_q <= 1'b1;
      end else if (data_rd_end && !cap_on_latch_q) begin
        new_q <= 1'b0;
      end

      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = &{1'b0, OPB_seqAddr, ack_wdata[31:2], ack_wdata[0], ack_be[3:1]};

endmodule

// File: doc/opb_register_simulink2ppc.md
# opb_register_simulink2ppc

OPB slave register carrying one 32-bit word from user fabric logic to the PowerPC, the read-direction counterpart of the PPC-to-fabric software register. The block captures user data on a valid strobe and exposes it to the PPC together with a status word holding a fresh-data flag, an overrun flag and a capture count. It sits on the shared OPB bus beside the other software registers. A read-ack pulse lets user logic pace its producer against PPC reads.

## Interface
- C_BASEADDR, 32'hFFFFFFFF: first byte address of the slave window
- C_HIGHADDR, 32'h00000000: last byte address of the window; the window is at least 8 bytes
- C_OPB_AWIDTH, 32: OPB address width
- C_OPB_DWIDTH, 32: OPB data width
- C_FAMILY, "virtex5": target family string; not used by the logic
- OPB_Clk  in  1  single clock; OPB bus and user logic both run on it
- OPB_Rst_n  in  1  asynchronous, active-low reset
- OPB_ABus  in  [0:31]  address (bit 0 = MSB)
- OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored; every transfer is a single beat
- Sl_DBus  out  [0:31]  read data; all zeros except during the ack cycle of a read
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0
- user_data_in  in  [31:0]  word from user logic
- user_data_valid  in  1  capture strobe
- user_read_ack  out  1  one-cycle pulse when the PPC reads the data word

## Operation
- Register map, as byte offsets from C_BASEADDR:
  - 0x0 DATA: read-only; writes are acked and ignored.
  - 0x4 STATUS:
    - bit0 NEW: set on capture, cleared by a DATA read.
    - bit1 OVR: set when a capture arrives while NEW=1; write 1 to clear.
    - bits[31:16] CNT: capture counter.
    - All other bits read 0.
  - Any other offset inside the window reads 0 and is acked; writes there have no effect.
- Address hit: C_BASEADDR <= OPB_ABus <= C_HIGHADDR, with OPB_select=1. The word is chosen by ABus[29]. No hit means no response.
- Capture: on user_data_valid=1, DATA <= user_data_in, NEW <= 1 and CNT increments. CNT wraps modulo 65536.
- OVR write-clear takes effect only when OPB_BE[3]=1 and DBus[30]=1.
- Bus-bit mapping: Sl_DBus[i] = reg[31-i].
- Slave FSM:
  - IDLE -> ACK on select && hit. Read data, the decoded offset and RNW are registered at this edge.
  - ACK (Sl_xferAck=1) -> GAP unconditionally.
  - GAP -> IDLE unconditionally. GAP ignores select, so one transfer is never acked twice.
- A DATA read asserts user_read_ack in the ACK cycle and clears NEW at the end of ACK.

## Timing
- Reset: every output and all state go to 0 asynchronously. FSM goes to IDLE.
- Reset asserted mid-transfer drops Sl_xferAck immediately. The master times out. That is acceptable.
- Latency: select is sampled at edge k; Sl_xferAck and Sl_DBus are valid from edge k+1 to edge k+2. Minimum 3 cycles between acks.
- Capture in the same cycle the FSM enters ACK for a DATA read:
  - The read returns the pre-capture value.
  - DATA, NEW and CNT update.
- Capture during the ACK cycle of a DATA read: NEW ends at 1 (set wins over clear), and OVR does not set.
- Capture with NEW=1 and no concurrent read: OVR <= 1, and DATA is overwritten.
- A capture and an OVR write-clear in the same cycle leave OVR set when the capture itself overruns.

## Structure
- Shared package (opb_sw_reg_pkg) holds:
  - FSM state typedef (IDLE, ACK, GAP)
  - offset constants DATA_OFS=0, STATUS_OFS=4
  - status bit positions NEW=0, OVR=1, CNT_LSB=16
- Natural sub-module: opb_slave_attach, containing the address decode, the IDLE/ACK/GAP FSM and the bus-bit reversal.
- The same attach is reusable by the PPC-to-fabric register.
- Register file and capture logic live in the top.

## Test plan
- **Reset and idle bus:** release reset, read STATUS -> 0x00000000; Sl_xferAck is high for exactly 1 cycle, 1 cycle after select.
- **Single capture:** pulse valid with 0xDEADBEEF, read DATA -> 0xDEADBEEF, user_read_ack pulses once; STATUS before -> 0x00010001, after -> 0x00010000.
- **Overrun:** two captures (0x1, 0x2) with no read -> STATUS 0x00020003 and DATA 0x2; write STATUS 0x00000002 with BE=4'b1111 -> OVR clears; the same write with BE=4'b1110 -> no change.
- **Capture coincident with read:** valid at the FSM's IDLE->ACK edge, data 0x55 replacing 0x44 -> read returns 0x44; STATUS after shows NEW=1 and OVR=0.
- **Counter wrap and back-to-back:** 65537 captures -> CNT=1. Select held high continuously -> acks are exactly 3 cycles apart. An address outside the window -> no ack.
